tl_ul_mem_responder: RTL

Single-outstanding TileLink-UL manager (slave) backed by a word-addressed memory array, used in the E76 testbench to terminate a TL-UL port that the TileLink monitor assert wrappers observe. It accepts Get, PutFullData and PutPartialData on channel A and returns AccessAckData or AccessAck on channel D after a programmable fixed delay. Illegal requests are answered with `denied`, and a saturating error count is kept. The block produces exactly the legal responder-side traffic that the monitors check.

---
 rtl/tl_ul_mem_responder.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/tl_ul_mem_responder.sv
// Single-outstanding TL-UL manager over a word memory; D beat follows A fire after RESP_DELAY idle cycles.
// a_ready is low while a response is pending; D fields hold steady until d_ready.
module tl_ul_mem_responder #(
  parameter int          SOURCE_W    = 4,
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          RESP_DELAY  = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                a_valid,
  output logic                a_ready,
  input  logic [2:0]          a_opcode,
  input  logic [2:0]          a_param,
  input  logic [1:0]          a_size,
  input  logic [SOURCE_W-1:0] a_source,
  input  logic [31:0]         a_address,
  input  logic [3:0]          a_mask,
  input  logic [31:0]         a_data,
  input  logic                a_corrupt,
  output logic                d_valid,
  input  logic                d_ready,
  output logic [2:0]          d_opcode,
  output logic [1:0]          d_param,
  output logic [1:0]          d_size,
  output logic [SOURCE_W-1:0] d_source,
  output logic                d_sink,
  output logic                d_denied,
  output logic [31:0]         d_data,
  output logic                d_corrupt,
  output logic [7:0]          err_count
);

  localparam int         IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [3:0] DELAY = 4'(RESP_DELAY);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic [2:0]          d_opcode_q;
  logic [1:0]          d_size_q;
  logic [SOURCE_W-1:0] d_source_q;
  logic                d_denied_q;
  logic [31:0]         d_data_q;
  logic                d_corrupt_q;
  logic [7:0]          err_q;

  logic             a_fire;
  logic [IDX_W-1:0] idx;
  logic             op_put_full, op_put_part, op_get, op_put, op_legal;
  logic [3:0]       lanes;
  logic             aligned, in_range, mask_ok, denied;
  logic [31:0]      rsp_data;
  logic             rsp_corrupt;
  logic             unused_corrupt;

  // Write data is committed regardless of a_corrupt.
  assign unused_corrupt = a_corrupt;

  assign idx    = a_address[IDX_W+1:2];
  assign a_fire = a_valid && a_ready;

  // Request legality; lanes are the byte lanes the access size/offset covers.
  always_comb begin
    op_put_full = (a_opcode == 3'd0);
    op_put_part = (a_opcode == 3'd1);
    op_get      = (a_opcode == 3'd4);
    op_put      = op_put_full || op_put_part;
    op_legal    = op_put || op_get;
    aligned     = 1'b0;
    lanes       = 4'h0;
    case (a_size)
      2'd0: begin
        aligned = 1'b1;
        lanes   = 4'b0001 << a_address[1:0];
      end
      2'd1: begin
        aligned = ~a_address[0];
        lanes   = a_address[1] ? 4'hC : 4'h3;
      end
      2'd2: begin
        aligned = (a_address[1:0] == 2'b00);
        lanes   = 4'hF;
      end
      default: begin
        aligned = 1'b0;
        lanes   = 4'h0;
      end
    endcase
    in_range = (a_address[31:IDX_W+2] == BASE_ADDR[31:IDX_W+2]);
    mask_ok  = !((op_put_full && (a_mask != lanes)) ||
                 (op_put && ((a_mask & ~lanes) != 4'h0)));
    denied   = !op_legal || (a_param != 3'd0) || (a_size == 2'd3) ||
               !aligned || !in_range || !mask_ok;
  end

  always_comb begin
    rsp_data    = 32'h0;
    rsp_corrupt = 1'b0;
    if (op_get) begin
      if (denied) rsp_corrupt = 1'b1;
      else        rsp_data    = mem[idx];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (a_fire) begin
          cnt_d   = DELAY;
          state_d = (DELAY == 4'd0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = RESP;
      end
      RESP: begin
        if (d_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // a_ready is masked during reset so no write can slip in under it.
  always_comb begin
    a_ready = (state_q == IDLE) && !reset;
    d_valid = (state_q == RESP);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      d_opcode_q  <= 3'd0;
      d_size_q    <= 2'd0;
      d_source_q  <= '0;
      d_denied_q  <= 1'b0;
      d_data_q    <= 32'h0;
      d_corrupt_q <= 1'b0;
    end else if (a_fire) begin
      d_opcode_q  <= op_get ? 3'd1 : 3'd0;
      d_size_q    <= a_size;
      d_source_q  <= a_source;
      d_denied_q  <= denied;
      d_data_q    <= rsp_data;
      d_corrupt_q <= rsp_corrupt;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      err_q <= 8'd0;
    end else if (a_fire && denied && (err_q != 8'hFF)) begin
      err_q <= err_q + 8'd1;
    end
  end

  // Backing store is deliberately left out of reset.
  always_ff @(posedge clock) begin
    if (a_fire && !denied && op_put) begin
      for (int b = 0; b < 4; b++) begin
        if (a_mask[b]) mem[idx][8*b +: 8] <= a_data[8*b +: 8];
      end
    end
  end

  assign d_opcode  = d_opcode_q;
  assign d_param   = 2'd0;
  assign d_size    = d_size_q;
  assign d_source  = d_source_q;
  assign d_sink    = 1'b0;
  assign d_denied  = d_denied_q;
  assign d_data    = d_data_q;
  assign d_corrupt = d_corrupt_q;
  assign err_count = err_q;

endmodule
